mips_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide controller that owns the HI/LO architectural registers for the harvard MIPS core.
- Replaces the single-cycle HI/LO path. Sequences MULT, MULTU, DIV and DIVU with an iterative shift-add / restoring-divide datapath.
- Exposes busy/done so the core stalls PC advance while an operation is in flight.
- Also services MTHI/MTLO writes; HI/LO reads (MFHI/MFLO) are combinational from outputs.

---
 rtl/mips_muldiv_pkg.sv | 20 ++
 rtl/mips_muldiv_unit_if.sv | 28 ++
 rtl/mips_muldiv_step.sv | 32 +++
 rtl/mips_muldiv_unit.sv | 130 +++++++++++++
 tb/tb_mips_muldiv_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
// Optional build macro: MIPS_MULDIV_FAST_MULT_EN (single-edge MULT/MULTU).
package mips_muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    localparam int MD_ITERS = 32;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Core-side bundle of the multiply/divide unit: request, MTHI/MTLO, status, HI/LO.
// master = core pipeline, slave = mips_muldiv_unit.
interface mips_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            hi_write;
    logic            lo_write;
    logic [XLEN-1:0] write_data;
    logic            busy;
    logic            done;
    logic            div_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, op1, op2, hi_write, lo_write, write_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, op1, op2, hi_write, lo_write, write_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_step.sv
// One combinational iteration: shift-add multiply (mode=0) or
// restoring divide (mode=1) on the {acc,opr} register pair.
module mips_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            mode,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] opr,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] opr_nxt
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shl;
    logic [XLEN-1:0] sub;
    logic            ge;

    // Multiply adds then shifts right; divide shifts left then trial-subtracts.
    always_comb begin
        sum = {1'b0, acc} + (opr[0] ? {1'b0, dvs} : '0);
        shl = {acc, opr[XLEN-1]};
        ge  = (shl >= {1'b0, dvs});
        sub = shl[XLEN-1:0] - dvs;
        if (mode) begin
            acc_nxt = ge ? sub : shl[XLEN-1:0];
            opr_nxt = {opr[XLEN-2:0], ge};
        end else begin
            acc_nxt = sum[XLEN:1];
            opr_nxt = {sum[0], opr[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller owning HI/LO.
// Define MIPS_MULDIV_FAST_MULT_EN for a one-edge combinational multiply.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = MD_ITERS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    mips_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] acc, opr, dvs, raw1;
    logic [XLEN-1:0] hi_q, lo_q;
    logic            neg_q, dsign_q, dz_q, busy_q, done_q;

    logic            in_signed, in_div, a_neg, b_neg, q_div;
    logic [XLEN-1:0] a_abs, b_abs, acc_nxt, opr_nxt;
    logic [XLEN-1:0] quot, rem;
    logic [2*XLEN-1:0] prod, prod_s;

    // Operand conditioning at accept and sign fix-up at the end.
    always_comb begin
        in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        in_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        a_neg     = in_signed & bus.op1[XLEN-1];
        b_neg     = in_signed & bus.op2[XLEN-1];
        a_abs     = a_neg ? -bus.op1 : bus.op1;
        b_abs     = b_neg ? -bus.op2 : bus.op2;
        q_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
`ifdef MIPS_MULDIV_FAST_MULT_EN
        prod      = {{XLEN{1'b0}}, dvs} * {{XLEN{1'b0}}, opr};
`else
        prod      = {acc, opr};
`endif
        prod_s    = neg_q ? -prod : prod;
        quot      = neg_q ? -opr : opr;
        rem       = dsign_q ? -acc : acc;
    end

    mips_muldiv_step #(.XLEN(XLEN)) u_step (
        .mode    (q_div),
        .acc     (acc),
        .opr     (opr),
        .dvs     (dvs),
        .acc_nxt (acc_nxt),
        .opr_nxt (opr_nxt)
    );

    // Sequencer: accept in IDLE, iterate in CALC, write HI/LO in FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= OP_MULT;
            acc     <= '0;
            opr     <= '0;
            dvs     <= '0;
            raw1    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            dsign_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clk_enable) begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        neg_q   <= a_neg ^ b_neg;
                        dsign_q <= a_neg;
                        raw1    <= bus.op1;
                        acc     <= '0;
                        opr     <= in_div ? a_abs : b_abs;
                        dvs     <= in_div ? b_abs : a_abs;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        dz_q    <= in_div && (bus.op2 == '0);
`ifdef MIPS_MULDIV_FAST_MULT_EN
                        state   <= in_div ? CALC : FIX;
`else
                        state   <= CALC;
`endif
                    end else begin
                        if (bus.hi_write) hi_q <= bus.write_data;
                        if (bus.lo_write) lo_q <= bus.write_data;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    opr <= opr_nxt;
                    if (cnt == LAST) state <= FIX;
                    else cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (!q_div) begin
                        hi_q <= prod_s[2*XLEN-1:XLEN];
                        lo_q <= prod_s[XLEN-1:0];
                    end else if (dz_q) begin
                        hi_q <= raw1;
                        lo_q <= DIV0_QUOT;
                    end else begin
                        hi_q <= rem;
                        lo_q <= quot;
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: latency, results, MTHI/MTLO,
// abort by reset and clock-enable freeze.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

`ifdef MIPS_MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
    localparam int INJ     = 0;
`else
    localparam int MUL_LAT = 33;
    localparam int INJ     = 9;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clk_enable = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    mips_muldiv_unit_if #(.XLEN(32)) bus();

    mips_muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        bus.op    = o;
        bus.op1   = a;
        bus.op2   = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!bus.done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        bus.start      = 1'b0;
        bus.op         = OP_MULT;
        bus.op1        = '0;
        bus.op2        = '0;
        bus.hi_write   = 1'b0;
        bus.lo_write   = 1'b0;
        bus.write_data = '0;
        repeat (2) tick();
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dz", bus.div_zero, 0);
        reset = 1'b0;
        tick();

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        check("t1_busy", bus.busy, 1);
        wait_done(0, lat);
        check("t1_lat", lat, MUL_LAT);
        check("t1_hi", bus.hi, 32'hFFFF_FFFF);
        check("t1_lo", bus.lo, 32'hFFFF_FFF1);
        check("t1_busy_lo", bus.busy, 0);
        tick();
        check("t1_pulse", bus.done, 0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(0, lat);
        check("t2_lat", lat, MUL_LAT);
        check("t2_hi", bus.hi, 32'h1);
        check("t2_lo", bus.lo, 32'hFFFF_FFFE);

        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(0, lat);
        check("mmin_hi", bus.hi, 32'h4000_0000);
        check("mmin_lo", bus.lo, 32'h0);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, lat);
        check("t3_lat", lat, DIV_LAT);
        check("t3_lo", bus.lo, 32'hFFFF_FFFD);
        check("t3_hi", bus.hi, 32'hFFFF_FFFF);
        check("t3_dz", bus.div_zero, 0);

        issue(OP_DIVU, 32'd7, 32'd0);
        wait_done(0, lat);
        check("dz_lo", bus.lo, 32'hFFFF_FFFF);
        check("dz_hi", bus.hi, 32'd7);
        check("dz_flag", bus.div_zero, 1);

        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (INJ) tick();
        bus.op         = OP_DIV;
        bus.op1        = 32'd50;
        bus.op2        = 32'd5;
        bus.start      = 1'b1;
        bus.lo_write   = 1'b1;
        bus.write_data = 32'hDEAD_BEEF;
        tick();
        bus.start    = 1'b0;
        bus.lo_write = 1'b0;
        wait_done(INJ + 1, lat);
        check("t4_lat", lat, MUL_LAT);
        check("t4_hi", bus.hi, 32'd0);
        check("t4_lo", bus.lo, 32'd12);
        check("t4_dzclr", bus.div_zero, 0);
        tick();
        check("t4_idle", bus.busy, 0);
        bus.lo_write   = 1'b1;
        bus.write_data = 32'h1234;
        tick();
        bus.lo_write = 1'b0;
        check("mtlo_lo", bus.lo, 32'h1234);
        check("mtlo_hi", bus.hi, 32'd0);
        bus.hi_write   = 1'b1;
        bus.lo_write   = 1'b1;
        bus.write_data = 32'hABCD;
        tick();
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        check("mtb_hi", bus.hi, 32'hABCD);
        check("mtb_lo", bus.lo, 32'hABCD);

        bus.hi_write   = 1'b1;
        bus.write_data = 32'h5555;
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        bus.hi_write = 1'b0;
        check("sw_hi", bus.hi, 32'hABCD);
        wait_done(0, lat);
        check("ovf_lo", bus.lo, 32'h8000_0000);
        check("ovf_hi", bus.hi, 32'h0);
        check("ovf_dz", bus.div_zero, 0);

        issue(OP_DIV, 32'd100, 32'd7);
        repeat (14) tick();
        check("t5_busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_hi", bus.hi, 0);
        check("t5_lo", bus.lo, 0);
        check("t5_busy0", bus.busy, 0);
        reset = 1'b0;
        issue(OP_DIV, 32'd100, 32'd7);
        wait_done(0, lat);
        check("t5b_lat", lat, DIV_LAT);
        check("t5b_lo", bus.lo, 32'd14);
        check("t5b_hi", bus.hi, 32'd2);

        issue(OP_DIVU, 32'd1000, 32'd7);
        repeat (5) tick();
        clk_enable = 1'b0;
        repeat (5) tick();
        check("t6_busy", bus.busy, 1);
        clk_enable = 1'b1;
        wait_done(10, lat);
        check("t6_lat", lat, DIV_LAT + 5);
        check("t6_lo", bus.lo, 32'd142);
        check("t6_hi", bus.hi, 32'd6);
        clk_enable = 1'b0;
        tick();
        check("t6_done_hold", bus.done, 1);
        clk_enable = 1'b1;
        tick();
        check("t6_done_end", bus.done, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
